data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Multi-cycle data-memory responder for the CPU's memory-access stage.
- Takes the CPU's READ/WRITE size codes, address and store data, and stalls the pipeline through BUSYWAIT until the access completes.
- Supports byte, half and word accesses, little-endian, with load sign/zero extension.
- Flags misaligned or illegal requests instead of performing them.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array; power of two.
- LATENCY, 2, array access cycles; legal range 1..15.

Ports:
- CLK  input  1  system clock, rising-edge active.
- RESET  input  1  asynchronous, active-high reset.
- READ  input  2  load size: 00 none, 01 byte, 10 half, 11 word.
- WRITE  input  2  store size, same encoding as READ.
- UNSIGNED  input  1  1 = zero-extend byte/half loads (LBU/LHU); ignored for word loads.
- ADDR  input  32  byte address.
- DATA_IN  input  32  store data; the low byte, half or word is used according to WRITE.
- DATA_OUT  output  32  load result, registered.
- BUSYWAIT  output  1  1 = CPU must stall and hold all request inputs stable.
- MISALIGN  output  1  error flag, registered; valid in the DONE cycle.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, counter=0, DATA_OUT=0, MISALIGN=0.
  - Array contents are NOT cleared by reset.
  - A reset mid-operation aborts the request; a pending store is discarded and the array is not written.
- Request: req = (READ!=00) | (WRITE!=00).
- Request capture: all request fields are captured into internal registers on the IDLE->ACCESS edge; later input changes have no effect on that request.
- Word index = ADDR[log2(DEPTH_WORDS)+1 : 2]. Upper address bits are ignored, so addresses alias (wrap) modulo 4*DEPTH_WORDS.
- FSM:
  - IDLE: BUSYWAIT = req (combinational). On an edge with req=1: capture request, counter=LATENCY-1, go to ACCESS. With req=0: stay.
  - ACCESS: BUSYWAIT=1. If counter!=0: decrement. If counter==0: perform the access, go to DONE.
  - DONE: BUSYWAIT=0; DATA_OUT and MISALIGN valid. Next edge always goes to IDLE, even if the request is still present; the CPU advances on this edge.
- Stall length: BUSYWAIT is high for exactly LATENCY+1 cycles per request. A back-to-back request sees one DONE cycle with BUSYWAIT=0 between accesses.
- Access performed at ACCESS exit:
  - Store: write only the selected byte lanes. Byte lane = ADDR[1:0]; half lane = ADDR[1]. DATA_OUT is unchanged.
  - Load: read the word, select the lane, sign-extend (UNSIGNED=0) or zero-extend (UNSIGNED=1), then register into DATA_OUT.
- Misalignment: half with ADDR[0]=1, or word with ADDR[1:0]!=00.
  - MISALIGN=1, no array write, DATA_OUT=0.
  - Timing is identical to a legal access.
- Illegal request: READ and WRITE both non-zero is treated as an error. MISALIGN=1, no write, DATA_OUT=0.
- MISALIGN is cleared on each new capture.
- No request in IDLE: outputs hold their last values.

Test Plan:
- Word store/load, LATENCY=2: WRITE=11, ADDR=0x10, DATA_IN=0xDEADBEEF -> BUSYWAIT high 3 cycles then low 1 cycle. Then READ=11, ADDR=0x10 -> DATA_OUT=0xDEADBEEF in DONE, MISALIGN=0.
- Byte lanes and extension: store word 0x80FF7F01 at 0x20.
  - READ=01, ADDR=0x22, UNSIGNED=0 -> DATA_OUT=0xFFFFFFFF.
  - READ=01, ADDR=0x22, UNSIGNED=1 -> DATA_OUT=0x000000FF.
  - READ=10, ADDR=0x22, UNSIGNED=0 -> DATA_OUT=0xFFFF80FF.
  - READ=01, ADDR=0x21 -> DATA_OUT=0x0000007F.
- Partial store: WRITE=01, ADDR=0x23, DATA_IN=0x000000AA onto 0x80FF7F01 -> word read at 0x20 = 0xAAFF7F01.
- Misaligned and illegal requests:
  - WRITE=11, ADDR=0x22 -> MISALIGN=1 in DONE; a following word read at 0x20 is unchanged.
  - READ=01 with WRITE=01 -> MISALIGN=1, DATA_OUT=0.
- Wrap-around: DEPTH_WORDS=256, store 0x12345678 at 0x400 -> word read at 0x000 returns 0x12345678.
- Reset mid-access: WRITE=11, ADDR=0x30, DATA_IN=0x55AA55AA; assert RESET during ACCESS -> BUSYWAIT=0 immediately, state IDLE, DATA_OUT=0. A later read of 0x30 returns the prior contents, not 0x55AA55AA.
- LATENCY=1 back-to-back requests held continuously -> BUSYWAIT pattern 1,1,0,1,1,0.

Source files
------------

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_responder
//  Purpose  : Multi-cycle data memory for the CPU memory-access stage.
//             Byte/half/word loads and stores, little-endian, with load
//             sign/zero extension. Misaligned or illegal (load+store)
//             requests raise MISALIGN instead of touching the array.
//  Ports    : CLK      - clock, rising edge
//             RESET    - asynchronous active-high reset
//             READ     - load size  (00 none, 01 byte, 10 half, 11 word)
//             WRITE    - store size (same encoding)
//             UNSIGNED - zero-extend byte/half loads when 1
//             ADDR     - byte address
//             DATA_IN  - store data (low byte/half/word used)
//             DATA_OUT - registered load result
//             BUSYWAIT - stall request to the CPU
//             MISALIGN - registered error flag, valid in the DONE cycle
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [1:0]  READ,
    input  logic [1:0]  WRITE,
    input  logic        UNSIGNED,
    input  logic [31:0] ADDR,
    input  logic [31:0] DATA_IN,
    output logic [31:0] DATA_OUT,
    output logic        BUSYWAIT,
    output logic        MISALIGN
);

    localparam int         c_IDX_W    = $clog2(DEPTH_WORDS);
    localparam int         c_ADDR_W   = c_IDX_W + 2;
    localparam logic [3:0] c_CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              r_state;
    logic [3:0]          r_count;
    logic [1:0]          r_read;
    logic [1:0]          r_write;
    logic                r_unsigned;
    logic [c_ADDR_W-1:0] r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_mem [DEPTH_WORDS];

    logic                w_req;
    logic [1:0]          w_size;
    logic                w_error;
    logic                w_finish;
    logic [c_IDX_W-1:0]  w_idx;
    logic [31:0]         w_rword;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_load;
    logic [3:0]          w_be;
    logic [31:0]         w_wword;
    logic                w_mem_we;

    // Address bits above the array span alias; they are deliberately dropped.
    logic                w_unused_addr;
    assign w_unused_addr = ^ADDR[31:c_ADDR_W];

    assign w_req    = (READ != 2'b00) || (WRITE != 2'b00);
    assign w_size   = (r_read != 2'b00) ? r_read : r_write;
    // Load and store together is illegal; otherwise check natural alignment.
    assign w_error  = ((r_read != 2'b00) && (r_write != 2'b00))
                   || ((w_size == 2'b10) && r_addr[0])
                   || ((w_size == 2'b11) && (r_addr[1:0] != 2'b00));
    assign w_finish = (r_state == S_ACCESS) && (r_count == 4'd0);
    assign w_idx    = r_addr[c_ADDR_W-1:2];
    assign w_rword  = r_mem[w_idx];
    assign w_byte   = w_rword[{r_addr[1:0], 3'b000} +: 8];
    assign w_half   = r_addr[1] ? w_rword[31:16] : w_rword[15:0];
    assign w_mem_we = w_finish && (r_write != 2'b00) && !w_error;

    always_comb begin
        w_load = 32'h0;
        case (r_read)
            2'b01:   w_load = r_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b10:   w_load = r_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            2'b11:   w_load = w_rword;
            default: w_load = 32'h0;
        endcase
    end

    // Replicate store data across lanes so the byte enables alone pick the target.
    always_comb begin
        w_be    = 4'b0000;
        w_wword = r_wdata;
        case (r_write)
            2'b01: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wword = {4{r_wdata[7:0]}};
            end
            2'b10: begin
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wword = {2{r_wdata[15:0]}};
            end
            2'b11: begin
                w_be    = 4'b1111;
                w_wword = r_wdata;
            end
            default: begin
                w_be    = 4'b0000;
                w_wword = r_wdata;
            end
        endcase
    end

    // Array has no reset; an async reset drops the FSM to IDLE so a pending
    // store never reaches w_mem_we.
    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_count    <= 4'd0;
            r_read     <= 2'b00;
            r_write    <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'h0;
            DATA_OUT   <= 32'h0;
            MISALIGN   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_read     <= READ;
                        r_write    <= WRITE;
                        r_unsigned <= UNSIGNED;
                        r_addr     <= ADDR[c_ADDR_W-1:0];
                        r_wdata    <= DATA_IN;
                        r_count    <= c_CNT_INIT;
                        MISALIGN   <= 1'b0;
                        r_state    <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_count != 4'd0) begin
                        r_count <= r_count - 4'd1;
                    end else begin
                        if (w_error) begin
                            MISALIGN <= 1'b1;
                            DATA_OUT <= 32'h0;
                        end else if (r_read != 2'b00) begin
                            DATA_OUT <= w_load;
                        end
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Stall as soon as a request appears in IDLE; released only in DONE.
    always_comb begin
        BUSYWAIT = 1'b0;
        case (r_state)
            S_IDLE:   BUSYWAIT = w_req && !RESET;
            S_ACCESS: BUSYWAIT = 1'b1;
            S_DONE:   BUSYWAIT = 1'b0;
            default:  BUSYWAIT = 1'b0;
        endcase
    end

endmodule
`default_nettype wire
